// File: rtl/lcd_cmd_arbiter.sv
// Two-requester round-robin arbiter that issues one command at a time to an LCD
// controller and waits for its busy handshake, with a timeout if busy never rises.
module lcd_cmd_arbiter #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [9:0] cmd0,
    input  logic [9:0] cmd1,
    output logic [1:0] ack,
    output logic       err,
    input  logic       lcd_busy,
    output logic       lcd_enable,
    output logic [9:0] lcd_bus,
    output logic       grant
);

    // state   | meaning
    // IDLE    | arbitrate when the controller is not busy
    // ISSUE   | lcd_enable high for this one cycle
    // WAIT_HI | wait for lcd_busy to rise, counting towards the timeout
    // WAIT_LO | wait for lcd_busy to fall, then acknowledge
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam int CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW:0] TIMEOUT_VAL = (CW + 1)'(ACK_TIMEOUT);

    state_t        state_q;
    logic [1:0]    ack_q;
    logic          err_q;
    logic          en_q;
    logic [9:0]    bus_q;
    logic          grant_q;
    logic          last_q;
    logic [CW-1:0] cnt_q;

    logic          pick_d;
    logic [CW:0]   cnt_inc;
    logic [CW-1:0] cnt_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_d = req[1];
        if (req == 2'b11) begin
            pick_d = ~last_q;
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign cnt_d   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_inc[CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            bus_q   <= 10'd0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            ack_q <= 2'b00;
            err_q <= 1'b0;
            en_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((req != 2'b00) && !lcd_busy) begin
                        grant_q <= pick_d;
                        bus_q   <= pick_d ? cmd1 : cmd0;
                        en_q    <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (lcd_busy) begin
                        state_q <= WAIT_LO;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_inc == TIMEOUT_VAL) begin
                            ack_q   <= grant_q ? 2'b10 : 2'b01;
                            err_q   <= 1'b1;
                            last_q  <= grant_q;
                            state_q <= IDLE;
                        end
                    end
                end
                WAIT_LO: begin
                    if (!lcd_busy) begin
                        ack_q   <= grant_q ? 2'b10 : 2'b01;
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign lcd_enable = en_q;
    assign lcd_bus    = bus_q;
    assign grant      = grant_q;

endmodule
